// File: rtl/valu_seq.sv
// valu_seq: sequential vector ALU with a valid/ready request/result handshake.
// Non-multiply ops finish in one EXEC cycle. Multiplies walk the vector one
// 64-bit slice per cycle through a single slice multiplier.
module valu_seq #(
    parameter int VLEN = 128
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [VLEN-1:0] reg_in1,
    input  logic [VLEN-1:0] reg_in2,
    input  logic [63:0]     reg_scalar_in,
    input  logic [3:0]      valu_op,
    input  logic [2:0]      SEW,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [VLEN-1:0] result,
    output logic            illegal
);

    localparam int MUL_CYCLES = VLEN / 64;
    localparam int NSLICE     = VLEN / 64;
    localparam int CNT_W      = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

    // Sign-extend the low element of a zero-extended operand to 64 bits.
    function automatic logic signed [63:0] sext(input logic [1:0] sew, input logic [63:0] x);
        logic signed [63:0] r;
        case (sew)
            2'd0:    r = {{56{x[7]}}, x[7:0]};
            2'd1:    r = {{48{x[15]}}, x[15:0]};
            2'd2:    r = {{32{x[31]}}, x[31:0]};
            default: r = x;
        endcase
        return r;
    endfunction

    // Replicate the low SEW bits of the scalar across a 64-bit slice.
    function automatic logic [63:0] rep_scalar(input logic [1:0] sew, input logic [63:0] s);
        logic [63:0] r;
        case (sew)
            2'd0:    r = {8{s[7:0]}};
            2'd1:    r = {4{s[15:0]}};
            2'd2:    r = {2{s[31:0]}};
            default: r = s;
        endcase
        return r;
    endfunction

    // One non-multiply element op on zero-extended operands; caller keeps the low SEW bits.
    function automatic logic [63:0] elem_alu(input logic [3:0] op, input logic [1:0] sew,
                                             input logic [63:0] a, input logic [63:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic [5:0]         sh;
        logic [63:0]        r;
        sa = sext(sew, a);
        sb = sext(sew, b);
        case (sew)
            2'd0:    sh = {3'b000, b[2:0]};
            2'd1:    sh = {2'b00, b[3:0]};
            2'd2:    sh = {1'b0, b[4:0]};
            default: sh = b[5:0];
        endcase
        case (op)
            4'd0, 4'd1: r = a + b;
            4'd2, 4'd3: r = a - b;
            4'd6:       r = a & b;
            4'd7:       r = a | b;
            4'd8:       r = a ^ b;
            4'd9:       r = (sa < sb) ? a : b;
            4'd10:      r = (sa > sb) ? a : b;
            4'd11:      r = a << sh;
            4'd12:      r = a >> sh;
            4'd13:      r = $unsigned(sa >>> sh);
            default:    r = '0;
        endcase
        return r;
    endfunction

    // Apply elem_alu to every element of a 64-bit slice; carries stay inside elements.
    function automatic logic [63:0] slice_alu(input logic [3:0] op, input logic [1:0] sew,
                                              input logic [63:0] a, input logic [63:0] b);
        logic [63:0] r;
        logic [63:0] e;
        r = '0;
        case (sew)
            2'd0: for (int i = 0; i < 8; i++) begin
                e = elem_alu(op, sew, {56'd0, a[i*8 +: 8]}, {56'd0, b[i*8 +: 8]});
                r[i*8 +: 8] = e[7:0];
            end
            2'd1: for (int i = 0; i < 4; i++) begin
                e = elem_alu(op, sew, {48'd0, a[i*16 +: 16]}, {48'd0, b[i*16 +: 16]});
                r[i*16 +: 16] = e[15:0];
            end
            2'd2: for (int i = 0; i < 2; i++) begin
                e = elem_alu(op, sew, {32'd0, a[i*32 +: 32]}, {32'd0, b[i*32 +: 32]});
                r[i*32 +: 32] = e[31:0];
            end
            default: r = elem_alu(op, sew, a, b);
        endcase
        return r;
    endfunction

    // Element-wise multiply of one 64-bit slice; the low SEW bits of the signed
    // product equal those of the unsigned product, so truncation is enough.
    function automatic logic [63:0] slice_mul(input logic [1:0] sew, input logic [63:0] a,
                                              input logic [63:0] b);
        logic [63:0] r;
        r = '0;
        case (sew)
            2'd0: for (int i = 0; i < 8; i++) r[i*8 +: 8] = a[i*8 +: 8] * b[i*8 +: 8];
            2'd1: for (int i = 0; i < 4; i++) r[i*16 +: 16] = a[i*16 +: 16] * b[i*16 +: 16];
            2'd2: for (int i = 0; i < 2; i++) r[i*32 +: 32] = a[i*32 +: 32] * b[i*32 +: 32];
            default: r = a * b;
        endcase
        return r;
    endfunction

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [VLEN-1:0]   result_q, result_d;
    logic              illegal_q, illegal_d;
    logic [VLEN-1:0]   a_q, a_d;
    logic [VLEN-1:0]   b_q, b_d;
    logic [63:0]       scal_q, scal_d;
    logic [3:0]        op_q, op_d;
    logic [2:0]        sew_q, sew_d;

    logic              is_vx;
    logic              is_mul;
    logic              bad_op;
    logic [63:0]       scal_rep;
    logic [VLEN-1:0]   alu_vec;
    logic [63:0]       mul_a;
    logic [63:0]       mul_b;
    logic [63:0]       mul_slice;

    // Datapath on the captured operands: full-width ALU result and the current multiply slice.
    always_comb begin
        is_vx    = (op_q == 4'd1) || (op_q == 4'd3) || (op_q == 4'd5);
        is_mul   = (op_q == 4'd4) || (op_q == 4'd5);
        bad_op   = sew_q[2] || (op_q[3:1] == 3'b111);
        scal_rep = rep_scalar(sew_q[1:0], scal_q);
        alu_vec  = '0;
        for (int k = 0; k < NSLICE; k++) begin
            alu_vec[k*64 +: 64] = slice_alu(op_q, sew_q[1:0], a_q[k*64 +: 64],
                                            is_vx ? scal_rep : b_q[k*64 +: 64]);
        end
        mul_a     = a_q[cnt_q*64 +: 64];
        mul_b     = is_vx ? scal_rep : b_q[cnt_q*64 +: 64];
        mul_slice = slice_mul(sew_q[1:0], mul_a, mul_b);
    end

    // Next-state logic: capture on accept, execute, then hold the result until consumed.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        illegal_d = illegal_q;
        a_d       = a_q;
        b_d       = b_q;
        scal_d    = scal_q;
        op_d      = op_q;
        sew_d     = sew_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = reg_in1;
                    b_d     = reg_in2;
                    scal_d  = reg_scalar_in;
                    op_d    = valu_op;
                    sew_d   = SEW;
                    cnt_d   = '0;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (bad_op) begin
                    result_d  = '0;
                    illegal_d = 1'b1;
                    state_d   = S_DONE;
                end else if (is_mul) begin
                    result_d[cnt_q*64 +: 64] = mul_slice;
                    illegal_d                = 1'b0;
                    if (cnt_q == CNT_W'(MUL_CYCLES - 1)) begin
                        cnt_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    result_d  = alu_vec;
                    illegal_d = 1'b0;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control state and visible outputs; reset drops any in-flight operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            result_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            illegal_q <= illegal_d;
        end
    end

    // Captured operands need no reset: they are only read after a fresh capture.
    always_ff @(posedge clk) begin
        a_q    <= a_d;
        b_q    <= b_d;
        scal_q <= scal_d;
        op_q   <= op_d;
        sew_q  <= sew_d;
    end

    assign in_ready  = (state_q == S_IDLE) && !rst;
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_valu_seq.sv
// Directed self-checking bench for valu_seq at VLEN = 128.
module tb_valu_seq;

    localparam int VLEN = 128;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [VLEN-1:0] reg_in1;
    logic [VLEN-1:0] reg_in2;
    logic [63:0]     reg_scalar_in;
    logic [3:0]      valu_op;
    logic [2:0]      SEW;
    logic            out_valid;
    logic            out_ready;
    logic [VLEN-1:0] result;
    logic            illegal;

    int vec_cnt = 0;
    int err_cnt = 0;

    valu_seq #(.VLEN(VLEN)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .reg_in1       (reg_in1),
        .reg_in2       (reg_in2),
        .reg_scalar_in (reg_scalar_in),
        .valu_op       (valu_op),
        .SEW           (SEW),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .result        (result),
        .illegal       (illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [VLEN-1:0] obs, input logic [VLEN-1:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request for a single edge; caller has already seen in_ready.
    task automatic start(input logic [3:0] op, input logic [2:0] sew, input logic [VLEN-1:0] a,
                         input logic [VLEN-1:0] b, input logic [63:0] s);
        valu_op       = op;
        SEW           = sew;
        reg_in1       = a;
        reg_in2       = b;
        reg_scalar_in = s;
        in_valid      = 1'b1;
        tick();
        in_valid      = 1'b0;
    endtask

    task automatic finish_hs(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_in_ready_back"}, in_ready, 1);
        check({tag, "_out_valid_drop"}, out_valid, 0);
    endtask

    logic [3:0]      sh_op  [3];
    logic [VLEN-1:0] sh_exp [3];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; out_ready = 1'b0;
        in_valid = 1'b1; valu_op = 4'd0; SEW = 3'd0;
        reg_in1 = {16{8'h11}}; reg_in2 = {16{8'h22}}; reg_scalar_in = 64'd0;

        // Reset state, with a request presented during reset
        tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_illegal", illegal, 0);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        check("in_ready_after_rst", in_ready, 1);
        tick();
        check("no_accept_in_rst_ov", out_valid, 0);
        check("no_accept_in_rst_ir", in_ready, 1);

        // Add 8-bit: 0xFF + 0x01 wraps to 0 per byte
        start(4'd0, 3'd0, {16{8'hFF}}, {16{8'h01}}, 64'd0);
        check("add8_lat0", out_valid, 0);
        check("add8_busy", in_ready, 0);
        tick();
        check("add8_lat1", out_valid, 1);
        check("add8_result", result, 0);
        check("add8_illegal", illegal, 0);
        finish_hs("add8");

        // Add 16-bit: no carry across halfwords, low byte carries into high byte
        start(4'd0, 3'd1, {8{16'h00FF}}, {8{16'h0001}}, 64'd0);
        tick();
        check("add16_result", result, {8{16'h0100}});
        finish_hs("add16");

        // Mul vx 16-bit: -1 * 3 = 0xFFFD, two EXEC cycles
        start(4'd5, 3'd1, {8{16'hFFFF}}, {8{16'h1234}}, 64'h0000_0000_0000_0003);
        check("mulvx_lat0", out_valid, 0);
        tick();
        check("mulvx_lat1", out_valid, 0);
        tick();
        check("mulvx_lat2", out_valid, 1);
        check("mulvx_result", result, {8{16'hFFFD}});
        finish_hs("mulvx");

        // Mul vv 64-bit: slice 0 is -1*2, slice 1 is 3*5
        start(4'd4, 3'd3, {64'd3, 64'hFFFF_FFFF_FFFF_FFFF}, {64'd5, 64'd2}, 64'd0);
        tick(); tick();
        check("mul64_valid", out_valid, 1);
        check("mul64_result", result, {64'd15, 64'hFFFF_FFFF_FFFF_FFFE});
        finish_hs("mul64");

        // Signed max / min 32-bit
        start(4'd10, 3'd2, {4{32'h8000_0000}}, {4{32'h0000_0001}}, 64'd0);
        tick();
        check("max32_result", result, {4{32'h0000_0001}});
        finish_hs("max32");
        start(4'd9, 3'd2, {4{32'h8000_0000}}, {4{32'h0000_0001}}, 64'd0);
        tick();
        check("min32_result", result, {4{32'h8000_0000}});
        finish_hs("min32");

        // Sub vx 32-bit: only the low 32 scalar bits count, 5 - 7 wraps
        start(4'd3, 3'd2, {4{32'd5}}, {4{32'hDEAD_BEEF}}, 64'hFFFF_FFFF_0000_0007);
        tick();
        check("subvx32_result", result, {4{32'hFFFF_FFFE}});
        finish_hs("subvx32");

        // Shifts 8-bit: shift element 0x09 means shift by 1
        sh_op[0] = 4'd13; sh_exp[0] = {16{8'hC0}};
        sh_op[1] = 4'd12; sh_exp[1] = {16{8'h40}};
        sh_op[2] = 4'd11; sh_exp[2] = {16{8'h00}};
        for (int i = 0; i < 3; i++) begin
            start(sh_op[i], 3'd0, {16{8'h80}}, {16{8'h09}}, 64'd0);
            tick();
            check($sformatf("shift8_op%0d", sh_op[i]), result, sh_exp[i]);
            finish_hs("shift8");
        end

        // Backpressure: result held, new request ignored until after handshake
        start(4'd7, 3'd0, {16{8'hF0}}, {16{8'h0F}}, 64'd0);
        tick();
        check("bp_first_valid", out_valid, 1);
        check("bp_first_result", result, {16{8'hFF}});
        for (int c = 0; c < 5; c++) begin
            if (c == 1) begin
                valu_op = 4'd8; SEW = 3'd0;
                reg_in1 = {16{8'hAA}}; reg_in2 = {16{8'hFF}};
                in_valid = 1'b1;
            end
            tick();
            check($sformatf("bp_hold_result_c%0d", c), result, {16{8'hFF}});
            check($sformatf("bp_in_ready_c%0d", c), in_ready, 0);
            check($sformatf("bp_out_valid_c%0d", c), out_valid, 1);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_hs_in_ready", in_ready, 1);
        check("bp_hs_out_valid", out_valid, 0);
        tick();
        in_valid = 1'b0;
        check("bp_accepted", in_ready, 0);
        tick();
        check("bp_second_valid", out_valid, 1);
        check("bp_second_result", result, {16{8'h55}});
        finish_hs("bp");

        // Reset during the first multiply slice
        start(4'd4, 3'd3, {64'd3, 64'd7}, {64'd5, 64'd9}, 64'd0);
        rst = 1'b1;
        tick();
        check("rstmul_out_valid", out_valid, 0);
        check("rstmul_result", result, 0);
        rst = 1'b0;
        #1;
        check("rstmul_in_ready", in_ready, 1);
        tick();
        check("rstmul_dropped", out_valid, 0);

        // Illegal SEW and illegal op code
        start(4'd0, 3'b100, {16{8'hFF}}, {16{8'h01}}, 64'd0);
        check("illsew_lat0", out_valid, 0);
        tick();
        check("illsew_valid", out_valid, 1);
        check("illsew_result", result, 0);
        check("illsew_flag", illegal, 1);
        finish_hs("illsew");
        start(4'd14, 3'd0, {16{8'h12}}, {16{8'h34}}, 64'd0);
        tick();
        check("illop_result", result, 0);
        check("illop_flag", illegal, 1);
        finish_hs("illop");

        // A legal op afterwards clears the flag
        start(4'd6, 3'd0, {16{8'h3C}}, {16{8'h0F}}, 64'd0);
        tick();
        check("and_result", result, {16{8'h0C}});
        check("and_illegal", illegal, 0);
        finish_hs("and");

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/valu_seq.md
# valu_seq

Sequential, parametrised successor of the combinational vector ALU. It accepts one vector operation per transaction over a valid/ready handshake and executes it on VLEN-bit registers. SEW sets the element width to 8, 16, 32 or 64 bits. Multiplies run iteratively through a 64-bit slice multiplier to bound area. It sits between the vector register file read stage and the write-back stage of the vector datapath.

## Interface
Parameters:
- VLEN, 128, vector register width in bits; legal range 64..512, multiple of 64
- MUL_CYCLES, VLEN/64 (derived, not overridable), number of EXEC cycles a multiply takes

Ports:
- clk  in  1  clock, all state updates on the rising edge
- rst  in  1  reset; one clock, synchronous, active-high
- in_valid  in  1  operation request
- in_ready  out  1  unit can accept a request
- reg_in1  in  VLEN  vector operand 1
- reg_in2  in  VLEN  vector operand 2
- reg_scalar_in  in  64  scalar operand; only its low SEW bits are used, replicated to every element
- valu_op  in  4  operation code
- SEW  in  3  element width: 000=8, 001=16, 010=32, 011=64 bits
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts the result
- result  out  VLEN  registered result
- illegal  out  1  registered flag: the op/SEW pair was unsupported

## Operation
- Op codes:
  - 0000 add vv; 0001 add vx; 0010 sub vv; 0011 sub vx.
  - 0100 mul vv; 0101 mul vx.
  - 0110 and; 0111 or; 1000 xor.
  - 1001 signed min vv; 1010 signed max vv.
  - 1011 sll vv; 1100 srl vv; 1101 sra vv.
- Add, sub and mul wrap modulo 2^SEW per element. No carry or borrow crosses element boundaries.
- Mul result is the low SEW bits of the signed product.
- Min and max compare elements as two's-complement SEW-bit values.
- Shift amount is the low log2(SEW) bits of the matching element of reg_in2. The upper bits are ignored.
- The bitwise ops (0110, 0111, 1000) ignore SEW.
- Illegal request: SEW in 100..111, or valu_op in 1110..1111.
  - Takes the ALU path: result = 0, illegal = 1.
  - Never hangs the unit.
- Operands, op and SEW are captured on acceptance. Later input changes are ignored.
- State machine:
  - IDLE: in_ready = 1. On in_valid & in_ready: capture operands, go to EXEC, clear slice counter.
  - EXEC, non-mul op or illegal: compute the whole vector in one cycle, register result/illegal, go to DONE.
  - EXEC, mul:
    - Each cycle compute the 64-bit slice selected by the counter (bits 64k+63..64k) and write it into result.
    - Increment the counter.
    - After slice MUL_CYCLES-1, go to DONE.
  - DONE: out_valid = 1. On out_ready, go to IDLE.
- in_ready = 1 only in IDLE. out_valid = 1 only in DONE.
- result and illegal hold their value from DONE until the next transaction writes them.
- rst in any state: go to IDLE and drop any in-flight operation. Same-cycle in_valid during rst is not accepted.

## Timing
- Reset values: in_ready = 1 after reset is released (0 while rst is high); out_valid = 0; result = 0; illegal = 0; slice counter = 0.
- Accept edge = t.
  - Non-mul: out_valid rises after edge t+1 (1-cycle latency).
  - Mul: out_valid rises after edge t+MUL_CYCLES (2 for VLEN = 128).
- Result is stable for the whole time out_valid is high, for any number of stall cycles.
- Handshake completes on the edge where out_valid & out_ready = 1. in_ready rises the next cycle.
- Throughput: one non-mul op per 3 cycles with out_ready tied high.
- in_valid while in_ready = 0 has no effect. The requester holds the request until in_ready = 1.

## Test plan
- Add 8-bit, VLEN=128: SEW=000, op 0000, reg_in1 bytes all 0xFF, reg_in2 bytes all 0x01.
  - Required: result = 0, illegal = 0, out_valid exactly 1 cycle after accept.
- Mul vx 16-bit: SEW=001, op 0101, reg_in1 halfwords 0xFFFF, reg_scalar_in = 0x...0003.
  - Required: every halfword = 0xFFFD, out_valid exactly 2 cycles after accept.
- Min/max 32-bit: SEW=010, reg_in1 words 0x80000000, reg_in2 words 0x00000001.
  - Required: op 1010 gives 0x00000001; op 1001 gives 0x80000000.
- Shifts 8-bit: SEW=000, element 0x80, shift element 0x09 (effective shift 1).
  - Required: op 1101 (sra) gives 0xC0; op 1100 (srl) gives 0x40; op 1011 (sll) gives 0x00.
- Backpressure: hold out_ready = 0 for 5 cycles after out_valid, pulse in_valid with new operands.
  - Required: result unchanged, in_ready = 0, new request not taken; accepted one cycle after out_ready handshake.
- Reset and illegal:
  - rst asserted during the mul slice-0 cycle. Required next cycle: out_valid = 0, result = 0, in_ready = 1.
  - Then SEW=100 with op 0000. Required: result = 0, illegal = 1 after 1 cycle.
